if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction fetch stage and IF/ID pipeline register of the 6-stage 16-bit core. Sits directly downstream of the PC register: takes the current PC, issues one request to instruction memory, and waits for the word. It then loads the IF/ID register and pulses `pc_advance` so the PC register steps. Decode stalls hold IF/ID. Redirects (branch/special writeback) flush IF/ID and discard any in-flight fetch.

## Interface
- `NOP_INSTR`, default 16'h0000: instruction word placed in IF/ID on reset and flush.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc_in` in 16: current PC from the PC register.
- `pc_plus_2_in` in 16: PC+2 from the PC register.
- `flush` in 1: redirect this cycle; OR of `branch_rr` and `special_wb`.
- `id_stall` in 1: decode cannot accept; hold IF/ID.
- `imem_req` out 1: fetch request strobe.
- `imem_addr` out 16: fetch address, halfword aligned.
- `imem_rdata` in 16: returned instruction word.
- `imem_valid` in 1: `imem_rdata` is valid; one-cycle pulse.
- `pc_advance` out 1: one-cycle pulse; the PC register steps at this edge (PC_Write term).
- `if_id_valid` out 1: IF/ID holds a live instruction.
- `if_id_instr` out 16: IF/ID instruction.
- `if_id_pc` out 16: PC of the IF/ID instruction.
- `if_id_pc_plus_2` out 16: PC+2 of the IF/ID instruction.

## Operation
- **States:** IDLE, REQ, WAIT, HOLD, DROP. Only one fetch is outstanding at any time.
- **IDLE:** entered on reset; goes to REQ on the next cycle.
- **REQ:**
  - Drives `imem_req`=1 and `imem_addr`={`pc_in`[15:1],0}.
  - Latches `pc_in` and `pc_plus_2_in` into `fetch_pc` and `fetch_pc2`.
  - Goes to WAIT. If `flush`=1 in REQ, the request is still issued but the state goes to DROP.
- **WAIT:** waits for `imem_valid`.
  - If `flush`=1, go to DROP, or to REQ if `imem_valid` is also 1 this cycle. The word is discarded.
  - Else if `imem_valid`=1 and `id_stall`=0: load IF/ID with {1, `imem_rdata`, `fetch_pc`, `fetch_pc2`}, pulse `pc_advance`, go to REQ.
  - Else if `imem_valid`=1 and `id_stall`=1: capture the word into the hold buffer, go to HOLD.
- **HOLD:**
  - `flush`=1: discard the buffer, go to REQ.
  - `id_stall`=0: load IF/ID from the buffer, pulse `pc_advance`, go to REQ.
- **DROP:** waits for `imem_valid`, discards the word, then goes to REQ. `flush` in DROP keeps the state in DROP.
- **IF/ID update priority (highest first):**
  1. `rst`
  2. `flush`: `if_id_valid`=0, `if_id_instr`=`NOP_INSTR`. Applies even while `id_stall`=1.
  3. `id_stall`: hold all IF/ID fields.
  4. Delivery: load the new word.
  5. Otherwise: `if_id_valid`=0 (bubble); other IF/ID fields hold.
- `imem_valid` in IDLE or REQ is ignored. Memory latency is at least 1 cycle.
- `pc_advance` is never asserted in a cycle where `flush`=1. The PC register takes the redirect target at that edge, and the next REQ uses the new `pc_in`.

## Timing
- **Reset values:**
  - state = IDLE
  - `imem_req`=0, `imem_addr`=0
  - `pc_advance`=0
  - `if_id_valid`=0, `if_id_instr`=`NOP_INSTR`, `if_id_pc`=0, `if_id_pc_plus_2`=0
  - hold buffer = 0
- Reset mid-fetch abandons the request. A late `imem_valid` after reset arrives in IDLE or REQ and is ignored.
- **Latency:**
  - Memory with L-cycle latency: one instruction per L+1 cycles; minimum 2 (REQ, WAIT).
  - For L=1: REQ at cycle t, `imem_valid` at t+1, IF/ID valid and PC updated from t+2, next REQ at t+2.
- `imem_req` is high exactly one cycle per fetch. `imem_addr` is valid only while `imem_req`=1.
- `pc_advance` and the IF/ID load happen at the same edge, so `if_id_pc`=old PC while `pc_in`=next PC.

## Test plan
- **Reset then run.** Stimulus: memory L=1 returning `A000`, `A002`, `A004` for PCs 0, 2, 4. Required: `imem_req` at cycles 1, 3, 5; `if_id_instr`/`if_id_pc` = `A000`/0, `A002`/2, `A004`/4 valid at cycles 3, 5, 7; `pc_advance` pulses at cycles 2, 4, 6.
- **Stall in WAIT.** Stimulus: `id_stall`=1 for 3 cycles while the word `1234` returns. Required: state goes to HOLD, IF/ID is unchanged, no `pc_advance`; after release `if_id_instr`=`1234` with one `pc_advance`.
- **Flush during WAIT, L=3.** Stimulus: `flush` one cycle after REQ. Required: the late word is discarded in DROP; the next `imem_addr` equals the redirected `pc_in`; `if_id_valid`=0 and `if_id_instr`=`NOP_INSTR` from the flush edge.
- **Flush plus stall in HOLD.** Stimulus: `flush`=1 and `id_stall`=1 simultaneously. Required: IF/ID is cleared, the buffer is discarded, REQ follows next cycle, no `pc_advance`.
- **Reset mid-fetch.** Stimulus: `rst` in WAIT, then a stray `imem_valid` with `BEEF` one cycle later. Required: `BEEF` is never in IF/ID; the first fetch after reset uses `pc_in`=0.
- **Odd PC.** Stimulus: `pc_in`=16'h0013. Required: `imem_addr`=16'h0012.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register: one outstanding imem request at a time,
// a hold buffer for words that return while decode is stalled, and redirect flushing.
// state  | meaning
// S_IDLE | first cycle after reset, no request yet
// S_REQ  | request strobe for pc_in, fetch PC latched
// S_WAIT | word outstanding and deliverable
// S_HOLD | returned word parked in the hold buffer while decode stalls
// S_DROP | word outstanding but killed by a redirect
module if_fetch_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    input  logic [15:0] pc_plus_2_in,
    input  logic        flush,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic        pc_advance,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc_plus_2
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] fetch_pc;
    logic [15:0] fetch_pc2;
    logic [15:0] hold_buf;
    logic        deliver;
    logic [15:0] deliver_word;
    logic        capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        imem_req     = 1'b0;
        imem_addr    = 16'h0000;
        deliver      = 1'b0;
        deliver_word = imem_rdata;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = {pc_in[15:1], 1'b0};
                state_nxt = flush ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = imem_valid ? S_REQ : S_DROP;
                end else if (imem_valid) begin
                    if (id_stall) begin
                        state_nxt = S_HOLD;
                    end else begin
                        deliver   = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                deliver_word = hold_buf;
                if (flush) begin
                    state_nxt = S_REQ;
                end else if (!id_stall) begin
                    deliver   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                // The outstanding word retires even if another redirect lands with it;
                // the PC register already holds the newest target for the next REQ.
                if (imem_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            imem_req  = 1'b0;
            imem_addr = 16'h0000;
            deliver   = 1'b0;
        end
    end

    assign pc_advance = deliver;
    assign capture    = (state == S_WAIT) && imem_valid && id_stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= 16'h0000;
            fetch_pc2 <= 16'h0000;
            hold_buf  <= 16'h0000;
        end else begin
            if (state == S_REQ) begin
                fetch_pc  <= pc_in;
                fetch_pc2 <= pc_plus_2_in;
            end
            if (capture) begin
                hold_buf <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_valid     <= 1'b0;
            if_id_instr     <= NOP_INSTR;
            if_id_pc        <= 16'h0000;
            if_id_pc_plus_2 <= 16'h0000;
        end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (id_stall) begin
            if_id_valid <= if_id_valid;
        end else if (deliver) begin
            if_id_valid     <= 1'b1;
            if_id_instr     <= deliver_word;
            if_id_pc        <= fetch_pc;
            if_id_pc_plus_2 <= fetch_pc2;
        end else begin
            if_id_valid <= 1'b0;
        end
    end

endmodule
